// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bundle for the serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor (a - b, LSB first) with start/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    // Single full-adder cell: opb already holds ~b and carry starts at 1, so this forms a + ~b + 1.
    logic sum_bit;
    logic carry_nxt;
    assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    logic last_bit;
    assign last_bit = (count_q == CW'(WIDTH - 1));

    // Next-state logic: capture operands in IDLE, shift one bit per cycle, publish results on the final bit.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        carry_d  = carry_q;
        count_d  = count_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    opa_d   = bus.a;
                    opb_d   = ~bus.b;
                    carry_d = 1'b1;
                    count_d = '0;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = carry_nxt;
                count_d = count_q + 1'b1;
                if (last_bit) begin
                    state_d  = ST_DONE;
                    diff_d   = {sum_bit, res_q[WIDTH-1:1]};
                    // Final carry of a + ~b + 1 is the inverse of the unsigned borrow.
                    borrow_d = ~carry_nxt;
                    // Signed overflow only when operand signs differ and the result sign departs from a.
                    ovf_d    = (a_msb_q != b_msb_q) & (sum_bit != a_msb_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (8-bit directed/random, 4-bit exhaustive)
module tb_serial_subtractor;
    logic clk;
    logic rst_n;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    int n_assert = 0;
    int n_fail   = 0;
    int done8_cnt = 0;
    int done4_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if8.done) done8_cnt <= done8_cnt + 1;
        if (if4.done) done4_cnt <= done4_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic void model(input int w, input int a, input int b,
                                  output int d, output int br, output int ov);
        int sa, sb, sd;
        d  = (a - b) & ((1 << w) - 1);
        br = (a < b) ? 1 : 0;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sd = sa - sb;
        ov = (sd > (1 << (w - 1)) - 1 || sd < -(1 << (w - 1))) ? 1 : 0;
    endfunction

    task automatic wait_done8(input string tag, output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!if8.done && edges < 40) begin
            if (if8.busy) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
        if (edges >= 40) check({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic op8(input string tag, input int a, input int b,
                       input int ed, input int ebr, input int eov);
        int edges, bc;
        if8.a = a[7:0];
        if8.b = b[7:0];
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        wait_done8(tag, edges, bc);
        check({tag, " latency"}, edges, 8);
        check({tag, " busy_cycles"}, bc, 8);
        check({tag, " diff"}, {24'd0, if8.diff}, ed);
        check({tag, " borrow"}, {31'd0, if8.borrow_out}, ebr);
        check({tag, " ovf"}, {31'd0, if8.overflow}, eov);
        check({tag, " busy_in_done"}, {31'd0, if8.busy}, 0);
        @(posedge clk); #1;
        check({tag, " done_pulse_width"}, {31'd0, if8.done}, 0);
    endtask

    initial begin
        int d, br, ov, edges, bc, snap;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {31'd0, if8.busy}, 0);
        check("rst done", {31'd0, if8.done}, 0);
        check("rst diff", {24'd0, if8.diff}, 0);
        check("rst borrow", {31'd0, if8.borrow_out}, 0);
        check("rst ovf", {31'd0, if8.overflow}, 0);
        check("rst4 diff", {28'd0, if4.diff}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed values with hand-derived expectations
        op8("5-3", 5, 3, 8'h02, 0, 0);
        op8("3-5", 3, 5, 8'hFE, 1, 0);
        op8("0-0", 0, 0, 8'h00, 0, 0);
        op8("80-01", 8'h80, 8'h01, 8'h7F, 0, 1);
        op8("7F-FF", 8'h7F, 8'hFF, 8'h80, 1, 1);
        op8("A5-00", 8'hA5, 0, 8'hA5, 0, 0);

        // Random operands against the reference model
        for (int i = 0; i < 20; i++) begin
            int ra, rb;
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            model(8, ra, rb, d, br, ov);
            op8($sformatf("rnd%0d", i), ra, rb, d, br, ov);
        end

        // Starts during SHIFT and DONE are ignored
        snap = done8_cnt;
        if8.a = 8'h20; if8.b = 8'h05; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if8.a = 8'h11; if8.b = 8'h22; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.a = 8'h33; if8.b = 8'h44;
        wait_done8("ign", edges, bc);
        check("ign diff", {24'd0, if8.diff}, 8'h1B);
        if8.a = 8'h55; if8.b = 8'h66; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        check("ign idle after done", {31'd0, if8.busy}, 0);
        repeat (15) @(posedge clk);
        #1;
        check("ign done count", done8_cnt - snap, 1);
        check("ign still idle", {31'd0, if8.busy}, 0);
        check("ign diff held", {24'd0, if8.diff}, 8'h1B);

        // Start held high relaunches after the DONE cycle, with operands captured at relaunch
        if8.a = 8'h09; if8.b = 8'h04; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.a = 8'h30; if8.b = 8'h01;
        wait_done8("hold1", edges, bc);
        check("hold1 diff", {24'd0, if8.diff}, 8'h05);
        @(posedge clk); #1;
        check("hold idle gap", {31'd0, if8.busy}, 0);
        @(posedge clk); #1;
        check("hold relaunch", {31'd0, if8.busy}, 1);
        if8.start = 1'b0;
        wait_done8("hold2", edges, bc);
        check("hold2 diff", {24'd0, if8.diff}, 8'h2F);
        check("hold2 borrow", {31'd0, if8.borrow_out}, 0);
        check("hold2 ovf", {31'd0, if8.overflow}, 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-SHIFT
        snap = done8_cnt;
        if8.a = 8'h40; if8.b = 8'h01; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #3;
        check("arst pre busy", {31'd0, if8.busy}, 1);
        check("arst pre diff", {24'd0, if8.diff}, 8'h2F);
        rst_n = 1'b0;
        #1;
        check("arst busy", {31'd0, if8.busy}, 0);
        check("arst done", {31'd0, if8.done}, 0);
        check("arst diff", {24'd0, if8.diff}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("arst no done", done8_cnt - snap, 0);
        check("arst idle", {31'd0, if8.busy}, 0);
        op8("post-rst 10-01", 8'h10, 8'h01, 8'h0F, 0, 0);

        // Exhaustive 4-bit sweep, back-to-back
        snap = done4_cnt;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int cyc;
                if4.a = a[3:0]; if4.b = b[3:0]; if4.start = 1'b1;
                @(posedge clk); #1;
                if4.start = 1'b0;
                cyc = 0;
                while (!if4.done && cyc < 20) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                model(4, a, b, d, br, ov);
                if (cyc >= 20) check($sformatf("w4 %0d-%0d timeout", a, b), 32'd0, 32'd1);
                check($sformatf("w4 %0d-%0d diff", a, b), {28'd0, if4.diff}, d);
                check($sformatf("w4 %0d-%0d borrow", a, b), {31'd0, if4.borrow_out}, br);
                check($sformatf("w4 %0d-%0d ovf", a, b), {31'd0, if4.overflow}, ov);
                @(posedge clk); #1;
            end
        end
        check("w4 done count", done4_cnt - snap, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
